pwm_duty_ramp: RTL

PWM_DUTY_RAMP -- requirements
Module: pwm_duty_ramp

---
 rtl/pwm_pkg.sv | 36 +++
 rtl/pwm_period_timer.sv | 35 +++
 rtl/pwm_duty_ramp.sv | 115 +++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty ramp block: duty width, FSM states,
// and the clamped step-toward-target arithmetic.
package pwm_pkg;

  localparam int DUTY_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // One ramp step toward tgt. The step is clamped to the remaining distance, so
  // the result never passes the target and never wraps past 0 or 255.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt,
    input logic [DUTY_W-1:0] step
  );
    logic [DUTY_W-1:0] diff;
    logic [DUTY_W-1:0] result;
    if (cur < tgt) begin
      diff   = tgt - cur;
      result = (step >= diff) ? tgt : cur + step;
    end else begin
      diff   = cur - tgt;
      result = (step >= diff) ? tgt : cur - step;
    end
    return result;
  endfunction

  // Square-law perceptual correction: (d*d)>>8, so 255 maps to 254.
  function automatic logic [DUTY_W-1:0] gamma8(input logic [DUTY_W-1:0] d);
    return DUTY_W'((16'(d) * 16'(d)) >> 8);
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter 0..PERIOD_LEN-1 with a registered one-cycle
// period_tick that is high while the count sits at its last value.
module pwm_period_timer #(
  parameter int PERIOD_LEN = 256
) (
  input  logic clock_in,
  input  logic reset_n,
  output logic period_tick
);

  localparam int CNT_W = (PERIOD_LEN > 1) ? $clog2(PERIOD_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_LEN - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             tick_reg;

  always_comb begin
    count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
  end

  // The tick is registered from the next count so it lines up with count==LAST.
  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      count_reg <= '0;
      tick_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tick_reg  <= (count_next == LAST);
    end
  end

  assign period_tick = tick_reg;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp controller: accepts a target/step, then walks the duty value
// toward the target once every RAMP_DIV PWM periods. Optional square-law output
// correction is enabled with the PWM_RAMP_GAMMA_EN macro.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int PERIOD_LEN = 256,
  parameter int RAMP_DIV   = 4
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [DUTY_W-1:0] tgt_step,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              period_tick,
  output logic              busy
);

  localparam logic [7:0] DIV_LAST = 8'(RAMP_DIV - 1);

  state_t            state_reg;
  logic [DUTY_W-1:0] duty_reg;
  logic [DUTY_W-1:0] target_reg;
  logic [DUTY_W-1:0] step_reg;
  logic [7:0]        div_reg;
  logic              ready_reg;
  logic              busy_reg;
  logic [DUTY_W-1:0] ramp_duty;

  pwm_period_timer #(
    .PERIOD_LEN(PERIOD_LEN)
  ) u_timer (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .period_tick(period_tick)
  );

  // A zero step means "jump straight to the target".
  always_comb begin
    ramp_duty = (step_reg == '0) ? target_reg
                                 : step_toward(duty_reg, target_reg, step_reg);
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      duty_reg   <= '0;
      target_reg <= '0;
      step_reg   <= '0;
      div_reg    <= '0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          // Acceptance never applies a step, even if it lands on a tick edge.
          if (tgt_valid && ready_reg) begin
            target_reg <= tgt_duty;
            step_reg   <= tgt_step;
            div_reg    <= '0;
            if (tgt_duty != duty_reg) begin
              state_reg <= RAMP;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (period_tick) begin
            if (step_reg == '0 || div_reg == DIV_LAST) begin
              duty_reg <= ramp_duty;
              div_reg  <= '0;
              if (ramp_duty == target_reg) begin
                state_reg <= IDLE;
                ready_reg <= 1'b1;
                busy_reg  <= 1'b0;
              end
            end else begin
              div_reg <= div_reg + 8'd1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign tgt_ready = ready_reg;
  assign busy      = busy_reg;

`ifdef PWM_RAMP_GAMMA_EN
  logic [DUTY_W-1:0] gamma_reg;

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      gamma_reg <= '0;
    end else begin
      gamma_reg <= gamma8(duty_reg);
    end
  end

  assign duty_cycle = gamma_reg;
`else
  assign duty_cycle = duty_reg;
`endif

endmodule
